seg_scan_mux: RTL and testbench

- Parametrised multiplexed seven-segment scan driver; successor to the fixed 3-digit win-timer display.
- Drives NUM_DIGITS common-anode digits from a packed hex/BCD bus, with an internal glyph decoder.
- Adds per-digit decimal points, leading-zero blanking, per-digit blink, anti-ghosting dead time and a tear-free frame snapshot.
- Sits between the game timer/score logic and the board display pins, clocked by the slow display clock.

---
 rtl/seg_scan_mux.sv | 196 +++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed common-anode seven-segment scan driver.
// Scans NUM_DIGITS digits MSB first from a snapshot taken once per frame,
// with glyph decode, decimal points, leading-zero blanking, per-digit blink
// and optional dead cycles between digit slots to suppress ghosting.
//
// Frame: LOAD (1) then per digit DRIVE (1) + DEAD (BLANK_CYCLES).
// All outputs are registered; inputs only matter at the LOAD edge, apart from
// enable, which forces IDLE on the next edge.
// dbg_state_o exposes the scan state: 0=IDLE 1=LOAD 2=DRIVE 3=DEAD.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    slclk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_blank,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic [1:0]              dbg_state_o
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [IW-1:0] TOP_IDX    = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [1:0]    DEAD_INIT  = (BLANK_CYCLES > 0) ? 2'(BLANK_CYCLES - 1) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRIVE = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  state_t                state_q;
  logic [IW-1:0]         idx_q;
  logic [1:0]            dead_q;
  logic [FW-1:0]         frame_q;
  logic                  phase_q;
  logic [3:0]            digit_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dpm_q;
  // Per-digit "keep dark" mask for the whole frame: leading-zero blanking
  // and blink are both resolved at LOAD so the frame cannot tear.
  logic [NUM_DIGITS-1:0] dark_q;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  fs_q;

  logic [NUM_DIGITS-1:0] lz_d;
  logic [NUM_DIGITS-1:0] dark_d;
  logic                  lz_run;
  logic [IW-1:0]         next_idx;
  logic [NUM_DIGITS-1:0] an_d;
  logic                  slot_done;
  logic                  go_load;
  logic                  go_drive;
  logic                  go_dead;

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;
  assign dbg_state_o = state_q;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Leading-zero mask from the live inputs, scanning down from the MSB digit;
  // blanking stops at the first non-zero digit or lit decimal point.
  always_comb begin
    lz_d   = '0;
    lz_run = lz_blank;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (lz_run && (i != 0) && (digits[4*i +: 4] == 4'd0) && !dp_mask[i]) begin
        lz_d[i] = 1'b1;
      end else begin
        lz_run = 1'b0;
      end
    end
    dark_d = lz_d | ((blink_en && phase_q) ? blink_mask : '0);
  end

  // Next slot index, its anode pattern and the transition decisions.
  always_comb begin
    next_idx  = (state_q == S_LOAD) ? TOP_IDX : (idx_q - IW'(1));
    an_d      = '1;
    an_d[next_idx] = 1'b0;
    slot_done = ((state_q == S_DRIVE) && (BLANK_CYCLES == 0)) ||
                ((state_q == S_DEAD) && (dead_q == 2'd0));
    go_load   = enable && ((state_q == S_IDLE) || (slot_done && (idx_q == '0)));
    go_drive  = enable && ((state_q == S_LOAD) || (slot_done && (idx_q != '0)));
    go_dead   = enable && (state_q == S_DRIVE) && (BLANK_CYCLES != 0);
  end

  // Scan FSM with registered display outputs, snapshot and blink timebase.
  always_ff @(posedge slclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dead_q  <= 2'd0;
      frame_q <= '0;
      phase_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'd0;
      dpm_q   <= '0;
      dark_q  <= '0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= '1;
      fs_q    <= 1'b0;
    end else if (!enable) begin
      // Frame counter and blink phase deliberately hold here.
      state_q <= S_IDLE;
      idx_q   <= '0;
      dead_q  <= 2'd0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= '1;
      fs_q    <= 1'b0;
    end else if (go_load) begin
      state_q <= S_LOAD;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digits[4*i +: 4];
      dpm_q   <= dp_mask;
      dark_q  <= dark_d;
      idx_q   <= TOP_IDX;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= '1;
      fs_q    <= 1'b1;
      // The phase seen by this frame is the value before this update.
      if (frame_q == FRAME_LAST) begin
        frame_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        frame_q <= frame_q + FW'(1);
      end
    end else if (go_drive) begin
      state_q <= S_DRIVE;
      idx_q   <= next_idx;
      fs_q    <= 1'b0;
      if (dark_q[next_idx]) begin
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
        an_q  <= '1;
      end else begin
        seg_q <= glyph(digit_q[next_idx]);
        dp_q  <= ~dpm_q[next_idx];
        an_q  <= an_d;
      end
    end else if (go_dead) begin
      state_q <= S_DEAD;
      dead_q  <= DEAD_INIT;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= '1;
      fs_q    <= 1'b0;
    end else begin
      // Remaining dead cycles of the current slot.
      dead_q  <= dead_q - 2'd1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= '1;
      fs_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Testbench for seg_scan_mux (4 digits, 1 dead cycle, 2-frame blink period).
// Outputs are compared once per cycle as {frame_start, an, dp, seg}.
module tb_seg_scan_mux;

  localparam int N  = 4;
  localparam int BC = 1;
  localparam int BF = 2;
  localparam int W  = 13;
  localparam logic [W-1:0] DARK  = {1'b0, 4'hF, 1'b1, 7'h7F};
  localparam logic [W-1:0] LOADV = {1'b1, 4'hF, 1'b1, 7'h7F};

  // ---------------- clock / reset ----------------
  logic slclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 slclk = ~slclk;

  logic          enable     = 1'b0;
  logic [15:0]   digits     = 16'h0;
  logic [3:0]    dp_mask    = 4'h0;
  logic          lz_blank   = 1'b0;
  logic          blink_en   = 1'b0;
  logic [3:0]    blink_mask = 4'h0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_start;
  logic [1:0]    dbg_state;
  logic [W-1:0]  dut_out;

  seg_scan_mux #(.NUM_DIGITS(N), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
    .slclk       (slclk),
    .rst_n       (rst_n),
    .enable      (enable),
    .digits      (digits),
    .dp_mask     (dp_mask),
    .lz_blank    (lz_blank),
    .blink_en    (blink_en),
    .blink_mask  (blink_mask),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start),
    .dbg_state_o (dbg_state)
  );

  assign dut_out = {frame_start, an, dp, seg};

  // ---------------- scoreboard / model ----------------
  int n_tests  = 0;
  int n_fail   = 0;
  int frame_no = 0;   // LOAD cycles since reset, as the model sees them
  logic [W-1:0] exp_q[$];

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dpm;
    logic        lz;
    logic [15:0] an_s;   // drive-slot anodes, digit 3 slot in the top nibble
    logic [27:0] seg_s;  // drive-slot segments, digit 3 slot in the top 7 bits
    logic [3:0]  dp_s;   // drive-slot dp, digit 3 slot in bit 3
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge slclk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic set_inputs(input logic [15:0] d, input logic [3:0] dpm, input logic lz,
                            input logic ben, input logic [3:0] bm);
    digits = d; dp_mask = dpm; lz_blank = lz; blink_en = ben; blink_mask = bm;
  endtask

  // Expected frame from the display rules: a digit is blanked when lz is set,
  // it is not digit 0, its value and everything above it is zero and no dp is
  // lit at or above it; blink phase is (frame number / BF) mod 2.
  task automatic push_frame(input logic [15:0] d, input logic [3:0] dpm, input logic lz,
                            input logic ben, input logic [3:0] bm);
    bit ph;
    bit blank;
    bit blinked;
    ph = ((frame_no / BF) % 2) == 1;
    exp_q.push_back(LOADV);
    for (int i = N - 1; i >= 0; i--) begin
      blank   = lz && (i != 0) && ((d >> (4 * i)) == 16'd0) && ((dpm >> i) == 4'd0);
      blinked = ben && ph && bm[i];
      if (blank || blinked) exp_q.push_back(DARK);
      else exp_q.push_back({1'b0, ~(4'b0001 << i), ~dpm[i], glyph_tab[d[4*i +: 4]]});
      for (int k = 0; k < BC; k++) exp_q.push_back(DARK);
    end
    frame_no++;
  endtask

  task automatic push_table(input vec_t v);
    exp_q.push_back(LOADV);
    for (int s = 0; s < N; s++) begin
      exp_q.push_back({1'b0, v.an_s[15-4*s -: 4], v.dp_s[3-s], v.seg_s[27-7*s -: 7]});
      for (int k = 0; k < BC; k++) exp_q.push_back(DARK);
    end
    frame_no++;
  endtask

  task automatic check_cycles(input int n, input string name, input bit scramble);
    logic [W-1:0] e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: expected queue empty at t=%0t", name, $time);
      end else begin
        e = exp_q.pop_front();
        check(name, dut_out, e);
      end
      if (scramble) set_inputs(16'($urandom), 4'($urandom), 1'($urandom),
                               1'($urandom), 4'($urandom));
    end
  endtask

  localparam int FL = 1 + N * (1 + BC);

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] rd;
    tbl[0] = '{16'h1234, 4'h0, 1'b0, 16'h7BDE,
               {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'hF};
    tbl[1] = '{16'h0005, 4'h0, 1'b1, 16'hFFFE,
               {7'h7F, 7'h7F, 7'h7F, 7'b0010010}, 4'hF};
    tbl[2] = '{16'h0005, 4'h0, 1'b0, 16'h7BDE,
               {7'b1000000, 7'b1000000, 7'b1000000, 7'b0010010}, 4'hF};
    tbl[3] = '{16'h0005, 4'b0100, 1'b1, 16'hFBDE,
               {7'h7F, 7'b1000000, 7'b1000000, 7'b0010010}, 4'b1011};
    tbl[4] = '{16'hABCD, 4'h0, 1'b0, 16'h7BDE,
               {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 4'hF};
    tbl[5] = '{16'h0000, 4'h0, 1'b1, 16'hFFFE,
               {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'hF};
    tbl[6] = '{16'h8F00, 4'b1010, 1'b1, 16'h7BDE,
               {7'b0000000, 7'b0001110, 7'b1000000, 7'b1000000}, 4'b0101};
    tbl[7] = '{16'hE09C, 4'b0001, 1'b0, 16'h7BDE,
               {7'b0000110, 7'b1000000, 7'b0010000, 7'b1000110}, 4'b1110};

    // Reset state
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_out", dut_out, DARK);
    end
    check("reset_state", {11'd0, dbg_state}, {11'd0, 2'd0});

    // Blink: frames 0-1 lit, 2-3 dark, 4 lit for digit 0
    set_inputs(16'h1234, 4'h0, 1'b0, 1'b1, 4'b0001);
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int f = 0; f < 5; f++) begin
      push_frame(16'h1234, 4'h0, 1'b0, 1'b1, 4'b0001);
      check_cycles(FL, "blink", 1'b0);
    end

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      set_inputs(tbl[v].d, tbl[v].dpm, tbl[v].lz, 1'b0, 4'h0);
      push_table(tbl[v]);
      check_cycles(FL, $sformatf("table%0d", v), 1'b0);
    end

    // Mid-frame input change is ignored until the next LOAD
    set_inputs(16'h1234, 4'h0, 1'b0, 1'b0, 4'h0);
    push_frame(16'h1234, 4'h0, 1'b0, 1'b0, 4'h0);
    check_cycles(4, "midframe_a", 1'b0);
    digits = 16'hABCD;
    check_cycles(FL - 4, "midframe_b", 1'b0);
    push_frame(16'hABCD, 4'h0, 1'b0, 1'b0, 4'h0);
    check_cycles(FL, "midframe_next", 1'b0);

    // Enable dropped in the dead slot after digit 2
    set_inputs(16'h1234, 4'h0, 1'b0, 1'b0, 4'h0);
    push_frame(16'h1234, 4'h0, 1'b0, 1'b0, 4'h0);
    check_cycles(5, "en_pre", 1'b0);
    enable = 1'b0;
    exp_q.delete();
    tick();
    check("en_off", dut_out, DARK);
    check("en_off_state", {11'd0, dbg_state}, {11'd0, 2'd0});
    tick();
    check("en_off_hold", dut_out, DARK);
    enable = 1'b1;
    push_frame(16'h1234, 4'h0, 1'b0, 1'b0, 4'h0);
    check_cycles(FL, "en_restart", 1'b0);

    // Randomized frames, inputs scrambled mid-frame
    for (int f = 0; f < 40; f++) begin
      rd = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
      set_inputs(rd, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                 1'($urandom), 1'($urandom), 4'($urandom));
      push_frame(digits, dp_mask, lz_blank, blink_en, blink_mask);
      check_cycles(FL, "random", 1'b1);
    end

    // Asynchronous reset mid-frame clears the blink timebase
    set_inputs(16'h1234, 4'h0, 1'b0, 1'b0, 4'h0);
    push_frame(16'h1234, 4'h0, 1'b0, 1'b0, 4'h0);
    check_cycles(3, "prereset", 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_out, DARK);
    check("async_reset_state", {11'd0, dbg_state}, {11'd0, 2'd0});
    exp_q.delete();
    frame_no = 0;
    tick();
    check("reset_hold", dut_out, DARK);
    rst_n = 1'b1;
    set_inputs(16'h1234, 4'h0, 1'b0, 1'b1, 4'b0001);
    for (int f = 0; f < 3; f++) begin
      push_frame(16'h1234, 4'h0, 1'b0, 1'b1, 4'b0001);
      check_cycles(FL, "post_reset_blink", 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
